// File: rtl/rom_bank_pkg.sv
// Shared types and defaults for the mapped program-storage bank.
// Optional parity storage is enabled with ROM_PARITY_EN.
package rom_bank_pkg;

  typedef enum logic [1:0] {
    LOCKED,
    ARMED,
    UNLOCKED
  } lock_state_t;

  localparam logic [7:0] UNLOCK_KEY0 = 8'hA5;
  localparam logic [7:0] UNLOCK_KEY1 = 8'h5A;

  localparam int unsigned DEF_DEPTH     = 32768;
  localparam int unsigned DEF_BASE      = 32'h8000;
  localparam int unsigned DEF_CTRL_ADDR = 32'h0004;

endpackage

// File: rtl/rom_lock_fsm.sv
// Two-key software unlock sequence guarding in-system programming.
// write_protect always wins and forces the sequence back to LOCKED.
module rom_lock_fsm
  import rom_bank_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ctrl_wr,
  input  logic       any_wr,
  input  logic [7:0] key,
  input  logic       write_protect,
  output logic       unlocked
);

  lock_state_t state, state_n;

  always_ff @(posedge clk) begin
    if (reset) state <= LOCKED;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (write_protect) begin
      state_n = LOCKED;
    end else begin
      unique case (state)
        LOCKED: begin
          if (ctrl_wr)
            state_n = (key == UNLOCK_KEY0) ? ARMED : LOCKED;
        end
        ARMED: begin
          // keys must arrive as consecutive writes
          if (ctrl_wr)
            state_n = (key == UNLOCK_KEY1) ? UNLOCKED : LOCKED;
          else if (any_wr)
            state_n = LOCKED;
        end
        UNLOCKED: begin
          if (ctrl_wr) state_n = LOCKED;
        end
        default: state_n = LOCKED;
      endcase
    end
  end

  assign unlocked = (state == UNLOCKED) && !write_protect;

endmodule

// File: rtl/mapped_rom_bank.sv
// Memory-mapped program-storage bank with lock control and read forwarding.
// Define ROM_PARITY_EN to store and check an even-parity bit per word.
module mapped_rom_bank
  import rom_bank_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned BASE      = DEF_BASE,
  parameter int unsigned CTRL_ADDR = DEF_CTRL_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              write_protect,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              data_oe,
`ifdef ROM_PARITY_EN
  output logic              parity_err,
`endif
  output logic              unlocked
);

  localparam int unsigned IDX_W =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef ROM_PARITY_EN
  localparam int unsigned MW = WIDTH + 1;
`else
  localparam int unsigned MW = WIDTH;
`endif

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(CTRL_ADDR);
  // one extra bit so a window ending at 2^ADDR_W is representable
  localparam logic [ADDR_W:0] LIMIT =
    (ADDR_W + 1)'(BASE + DEPTH);

  logic [MW-1:0] mem [DEPTH];

  logic             rd_hit, rd_ctrl;
  logic             wr_hit, wr_ctrl, wr_ok;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [MW-1:0]    rd_word, wr_word;
  logic             fwd;
  logic [WIDTH-1:0] ctrl_word;
  logic             par_sticky;

  assign rd_hit  = (rd_addr >= BASE_A) &&
                   ({1'b0, rd_addr} < LIMIT);
  assign wr_hit  = (wr_addr >= BASE_A) &&
                   ({1'b0, wr_addr} < LIMIT);
  assign rd_ctrl = (rd_addr == CTRL_A);
  assign wr_ctrl = (wr_addr == CTRL_A);
  assign rd_idx  = IDX_W'(rd_addr - BASE_A);
  assign wr_idx  = IDX_W'(wr_addr - BASE_A);
  assign wr_ok   = wr_req && wr_hit && unlocked;
  assign fwd     = wr_ok && (wr_idx == rd_idx);
  assign rd_word = mem[rd_idx];

`ifdef ROM_PARITY_EN
  assign wr_word = {^wr_data, wr_data};
`else
  assign wr_word = wr_data;
  assign par_sticky = 1'b0;
`endif

  always_comb begin
    ctrl_word    = '0;
    ctrl_word[0] = unlocked;
    ctrl_word[1] = par_sticky;
  end

  rom_lock_fsm u_lock (
    .clk           (clk),
    .reset         (reset),
    .ctrl_wr       (wr_req && wr_ctrl),
    .any_wr        (wr_req),
    .key           (wr_data[7:0]),
    .write_protect (write_protect),
    .unlocked      (unlocked)
  );

  always_ff @(posedge clk) begin
    if (!reset && wr_ok) mem[wr_idx] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      data_oe  <= 1'b0;
    end else begin
      rd_valid <= rd_req && (rd_hit || rd_ctrl);
      unique case (1'b1)
        rd_req && rd_hit:
          rd_data <= fwd ? wr_data : rd_word[WIDTH-1:0];
        rd_req && rd_ctrl:
          rd_data <= ctrl_word;
        default: ;
      endcase
      if (wr_req)      data_oe <= 1'b0;
      else if (rd_req) data_oe <= rd_hit || rd_ctrl;
    end
  end

`ifdef ROM_PARITY_EN
  logic par_bad;
  // a forwarded word never came from storage, so it cannot be corrupt
  assign par_bad = rd_req && rd_hit && !fwd && (^rd_word);

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err <= 1'b0;
      par_sticky <= 1'b0;
    end else begin
      parity_err <= par_bad;
      if (par_bad) par_sticky <= 1'b1;
    end
  end
`endif

endmodule
